param_readback_tx: RTL

UART transmitter that sends the live pulse-parameter set back to the host PC over RS232_Tx. It is the return path of the command receiver.
- On a one-cycle start request it snapshots all parameter registers, then serialises a fixed framed byte stream, 8N1, LSB-first per byte.
- It sits beside the command receiver in the pulse generator top level, on the same clock.
- The host uses it to confirm that written parameters took effect.

---
 rtl/pulse_pkg.sv | 30 +++
 rtl/uart_tx_byte.sv | 92 +++++++++
 rtl/param_readback_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator host link: frame layout and UART tx states.
package pulse_pkg;

  localparam logic [7:0] FRAME_HDR        = 8'hA5;
  localparam int         FRAME_BYTES_BASE = 16;

  // Byte positions within the readback frame; multi-byte fields go MSB-byte first.
  localparam logic [4:0] IDX_HDR     = 5'd0;
  localparam logic [4:0] IDX_PER_B3  = 5'd1;
  localparam logic [4:0] IDX_PER_B2  = 5'd2;
  localparam logic [4:0] IDX_PER_B1  = 5'd3;
  localparam logic [4:0] IDX_PER_B0  = 5'd4;
  localparam logic [4:0] IDX_P1WID_H = 5'd5;
  localparam logic [4:0] IDX_P1WID_L = 5'd6;
  localparam logic [4:0] IDX_DEL_H   = 5'd7;
  localparam logic [4:0] IDX_DEL_L   = 5'd8;
  localparam logic [4:0] IDX_P2WID_H = 5'd9;
  localparam logic [4:0] IDX_P2WID_L = 5'd10;
  localparam logic [4:0] IDX_NUTD_H  = 5'd11;
  localparam logic [4:0] IDX_NUTD_L  = 5'd12;
  localparam logic [4:0] IDX_NUTW    = 5'd13;
  localparam logic [4:0] IDX_PR_ATT  = 5'd14;
  localparam logic [4:0] IDX_FLAGS   = 5'd15;
  localparam logic [4:0] IDX_CKSUM   = 5'd16;

  typedef enum logic [2:0] {IDLE, START_BIT, DATA, STOP_BIT, DONE} tx_state_t;

  typedef enum logic [1:0] {FR_IDLE, FR_SEND, FR_DONE} frame_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser, LSB first, CLKS_PER_BIT clocks per bit; tx idles high.
module uart_tx_byte
  import pulse_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output tx_state_t  o_state
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t   r_state, w_state_nxt;
  logic [15:0] r_baud, w_baud_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_tx, w_tx_nxt;
  logic        w_bit_end;
  logic        w_accept;

  // Handshake: a byte moves on any cycle with i_valid && o_ready; i_valid never
  // waits on o_ready. o_ready is high in IDLE/DONE and in the last cycle of a
  // stop bit, so a byte offered there starts its start bit with no idle gap.
  assign w_bit_end = (r_baud == BAUD_LAST);
  assign o_ready   = (r_state == IDLE) || (r_state == DONE) ||
                     ((r_state == STOP_BIT) && w_bit_end);
  assign w_accept  = i_valid && o_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_bit_end ? 16'd0 : r_baud + 16'd1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;
    case (r_state)
      IDLE, DONE: begin
        w_baud_nxt  = 16'd0;
        w_state_nxt = IDLE;
        if (w_accept) begin
          w_state_nxt = START_BIT;
          w_shift_nxt = i_data;
        end
      end
      START_BIT: if (w_bit_end) begin
        w_state_nxt = DATA;
        w_bit_nxt   = 3'd0;
      end
      DATA: if (w_bit_end) begin
        w_shift_nxt = {1'b0, r_shift[7:1]};
        w_bit_nxt   = r_bit + 3'd1;
        if (r_bit == 3'd7) w_state_nxt = STOP_BIT;
      end
      STOP_BIT: if (w_bit_end) begin
        if (w_accept) begin
          w_state_nxt = START_BIT;
          w_shift_nxt = i_data;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // tx is registered from the next state so the line never sees decode glitches
    if (w_state_nxt == START_BIT) w_tx_nxt = 1'b0;
    else if (w_state_nxt == DATA) w_tx_nxt = w_shift_nxt[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign o_tx    = r_tx;
  assign o_state = r_state;

endmodule

// File: rtl/param_readback_tx.sv
// Snapshots the pulse parameters on start and streams them to the host as one 8N1 frame.
// Define READBACK_CKSUM_EN to append an XOR checksum byte (17-byte frame instead of 16).
module param_readback_tx
  import pulse_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] per,
  input  logic [15:0] p1wid,
  input  logic [15:0] del,
  input  logic [15:0] p2wid,
  input  logic [15:0] nut_d,
  input  logic [7:0]  nut_w,
  input  logic [6:0]  pr_att,
  input  logic        cp,
  input  logic        bl,
  output logic        busy,
  output logic        done,
  output logic        tx
);

`ifdef READBACK_CKSUM_EN
  localparam int FRAME_BYTES = FRAME_BYTES_BASE + 1;
`else
  localparam int FRAME_BYTES = FRAME_BYTES_BASE;
`endif
  localparam logic [4:0] FRAME_END = 5'(FRAME_BYTES);

  frame_state_t r_fstate, w_fstate_nxt;
  logic [4:0]   r_idx;
  logic [31:0]  r_per;
  logic [15:0]  r_p1wid, r_del, r_p2wid, r_nut_d;
  logic [7:0]   r_nut_w;
  logic [6:0]   r_pr_att;
  logic         r_cp, r_bl;
  logic         w_valid, w_ready, w_hs, w_load, w_ser_tx;
  logic [7:0]   w_data;
  tx_state_t    w_ser_state;

  // The header goes out straight from the start cycle; later bytes come from the snapshot.
  assign w_valid = ((r_fstate == FR_IDLE) && start) ||
                   ((r_fstate == FR_SEND) && (r_idx != FRAME_END));
  assign w_hs    = w_valid && w_ready;
  assign w_load  = w_hs && (r_fstate == FR_IDLE);

`ifdef READBACK_CKSUM_EN
  logic [7:0] r_cksum;

  always_ff @(posedge clk) begin
    if (w_load) r_cksum <= FRAME_HDR;
    else if (w_hs && (r_idx != IDX_CKSUM)) r_cksum <= r_cksum ^ w_data;
  end
`endif

  always_comb begin
    w_data = FRAME_HDR;
    if (r_fstate == FR_SEND) begin
      case (r_idx)
        IDX_PER_B3:  w_data = r_per[31:24];
        IDX_PER_B2:  w_data = r_per[23:16];
        IDX_PER_B1:  w_data = r_per[15:8];
        IDX_PER_B0:  w_data = r_per[7:0];
        IDX_P1WID_H: w_data = r_p1wid[15:8];
        IDX_P1WID_L: w_data = r_p1wid[7:0];
        IDX_DEL_H:   w_data = r_del[15:8];
        IDX_DEL_L:   w_data = r_del[7:0];
        IDX_P2WID_H: w_data = r_p2wid[15:8];
        IDX_P2WID_L: w_data = r_p2wid[7:0];
        IDX_NUTD_H:  w_data = r_nut_d[15:8];
        IDX_NUTD_L:  w_data = r_nut_d[7:0];
        IDX_NUTW:    w_data = r_nut_w;
        IDX_PR_ATT:  w_data = {1'b0, r_pr_att};
        IDX_FLAGS:   w_data = {6'b0, r_bl, r_cp};
`ifdef READBACK_CKSUM_EN
        IDX_CKSUM:   w_data = r_cksum;
`endif
        default:     w_data = FRAME_HDR;
      endcase
    end
  end

  // Frame ends at the end of the last stop bit: serialiser ready with nothing left to offer.
  always_comb begin
    w_fstate_nxt = r_fstate;
    case (r_fstate)
      FR_IDLE: if (w_hs) w_fstate_nxt = FR_SEND;
      FR_SEND: if ((r_idx == FRAME_END) && (w_ser_state == STOP_BIT) && w_ready)
                 w_fstate_nxt = FR_DONE;
      FR_DONE: w_fstate_nxt = FR_IDLE;
      default: w_fstate_nxt = FR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fstate <= FR_IDLE;
      r_idx    <= 5'd0;
    end else begin
      r_fstate <= w_fstate_nxt;
      if (w_load)    r_idx <= 5'd1;
      else if (w_hs) r_idx <= r_idx + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_per    <= per;
      r_p1wid  <= p1wid;
      r_del    <= del;
      r_p2wid  <= p2wid;
      r_nut_d  <= nut_d;
      r_nut_w  <= nut_w;
      r_pr_att <= pr_att;
      r_cp     <= cp;
      r_bl     <= bl;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk    (clk),
    .reset  (reset),
    .i_valid(w_valid),
    .o_ready(w_ready),
    .i_data (w_data),
    .o_tx   (w_ser_tx),
    .o_state(w_ser_state)
  );

  assign busy = (r_fstate == FR_SEND);
  assign done = (r_fstate == FR_DONE);
  assign tx   = w_ser_tx;

endmodule
